// File: rtl/mdu_pkg.sv
// ==========================================================================
// mdu_pkg: M-extension decode constants, FSM state and unit encodings.
// Revision: 1.0
// ==========================================================================
`default_nettype none

package mdu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef logic [1:0] state_e;
  localparam state_e IDLE     = 2'd0;
  localparam state_e DISPATCH = 2'd1;
  localparam state_e WAIT     = 2'd2;
  localparam state_e RESP     = 2'd3;

  typedef enum logic {
    UNIT_MUL = 1'b0,
    UNIT_DIV = 1'b1
  } unit_e;

  function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  endfunction

  function automatic unit_e unit_of(input logic [2:0] funct3);
    funct3_e f3;
    f3 = funct3_e'(funct3);
    return (f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU}) ? UNIT_DIV : UNIT_MUL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_if.sv
// ==========================================================================
// mdu_if: issue-port, mul/div unit and response handshakes of the MDU scheduler.
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface mdu_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*32-1:0]   req_instr;
  logic [NUM_REQ*XLEN-1:0] req_a;
  logic [NUM_REQ*XLEN-1:0] req_b;

  logic            mul_valid;
  logic            mul_ready;
  logic            mul_done;
  logic [XLEN-1:0] mul_result;
  logic            div_valid;
  logic            div_ready;
  logic            div_done;
  logic [XLEN-1:0] div_result;

  logic [31:0]     unit_instr;
  logic [XLEN-1:0] unit_a;
  logic [XLEN-1:0] unit_b;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  modport master (
    input  req_valid, req_instr, req_a, req_b,
    input  mul_ready, mul_done, mul_result,
    input  div_ready, div_done, div_result,
    input  rsp_ready,
    output req_ready, mul_valid, div_valid,
    output unit_instr, unit_a, unit_b,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_instr, req_a, req_b,
    output mul_ready, mul_done, mul_result,
    output div_ready, div_done, div_result,
    output rsp_ready,
    input  req_ready, mul_valid, div_valid,
    input  unit_instr, unit_a, unit_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/mdu_rr_arbiter.sv
// ==========================================================================
// mdu_rr_arbiter: round-robin one-hot grant; pointer moves past the winner on grant.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module mdu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_any_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int              j;
    logic [ID_W-1:0] idx;
    j         = 0;
    idx       = '0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = ID_W'(j);
      if (en_i && !gnt_any_o && req_i[idx]) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = idx;
      end
    end
    gnt_o[gnt_idx_o] = gnt_any_o;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = (gnt_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/mdu_scheduler.sv
// ==========================================================================
// mdu_scheduler: shares one MUL and one DIV unit among NUM_REQ issue ports, one op in flight.
// Revision: 1.0   (optional WAIT watchdog: define MDU_TIMEOUT_EN)
// ==========================================================================
`default_nettype none

module mdu_scheduler
  import mdu_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic   clk,
  input  logic   reset,
  mdu_if.master  bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || XLEN < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mdu_scheduler: requires NUM_REQ >= 2, XLEN >= 1, TIMEOUT_CYCLES >= 1");
  end

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [ID_W-1:0] id_q, id_d;
  unit_e           unit_q, unit_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;
  logic [31:0]     sel_instr;
  logic            unit_ready, unit_done;
  logic [XLEN-1:0] unit_result;

  mdu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (bus.req_valid),
    .en_i      (state_q == IDLE),
    .gnt_o     (bus.req_ready),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign sel_instr   = bus.req_instr[gnt_idx*32 +: 32];
  assign unit_ready  = (unit_q == UNIT_DIV) ? bus.div_ready  : bus.mul_ready;
  assign unit_done   = (unit_q == UNIT_DIV) ? bus.div_done   : bus.mul_done;
  assign unit_result = (unit_q == UNIT_DIV) ? bus.div_result : bus.mul_result;

`ifdef MDU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wdog_q, wdog_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    unit_d  = unit_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef MDU_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          instr_d = sel_instr;
          a_d     = bus.req_a[gnt_idx*XLEN +: XLEN];
          b_d     = bus.req_b[gnt_idx*XLEN +: XLEN];
          id_d    = gnt_idx;
          unit_d  = unit_of(sel_instr[14:12]);
          if (is_m_op(sel_instr[6:0], sel_instr[31:25])) begin
            state_d = DISPATCH;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      DISPATCH: begin
`ifdef MDU_TIMEOUT_EN
        wdog_d = '0;
`endif
        if (unit_ready) state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the final watchdog cycle still wins over the timeout.
        if (unit_done) begin
          data_d  = unit_result;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef MDU_TIMEOUT_EN
        else if (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      unit_q  <= UNIT_MUL;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      unit_q  <= unit_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.mul_valid  = (state_q == DISPATCH) && (unit_q == UNIT_MUL);
  assign bus.div_valid  = (state_q == DISPATCH) && (unit_q == UNIT_DIV);
  assign bus.unit_instr = instr_q;
  assign bus.unit_a     = a_q;
  assign bus.unit_b     = b_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_err    = err_q;

endmodule

`default_nettype wire
